// File: rtl/btn_conditioner_if.sv
// Button front-end bus: raw pins in, debounced level and event pulses out.
// Outputs are registered in the conditioner; there is no backpressure on this bus.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rel;
  logic [NUM_BTN-1:0] rpt;

  modport master (output btn_raw, input level, press, rel, rpt);
  modport slave  (input btn_raw, output level, press, rel, rpt);
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel sync + debounce + press/release pulses + hold-to-repeat; level/press/rel land
// 2+STABLE_CNT edges after a raw change. All outputs registered; no backpressure (pulses are fire-and-forget).
module btn_conditioner #(
  parameter int NUM_BTN      = 5,
  parameter int CNT_W        = 20,
  parameter int STABLE_CNT   = 1000000,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_EN    = 1,
  parameter int RPT_W        = 26,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input logic              clk,
  input logic              rst,
  btn_conditioner_if.slave bus
);

  localparam logic [NUM_BTN-1:0] POL        = {NUM_BTN{ACTIVE_LOW != 0}};
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_CNT - 1);
  localparam logic [RPT_W-1:0]   DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]   RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  logic [NUM_BTN-1:0] sync_a;
  logic [NUM_BTN-1:0] sync_b;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] rel_q;
  logic [NUM_BTN-1:0] rpt_q;

  // Polarity is folded in before the synchroniser so everything downstream is active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= bus.btn_raw ^ POL;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip = (sync_b[i] != level_q[i]) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt        <= '0;
        level_q[i] <= 1'b0;
        press_q[i] <= 1'b0;
        rel_q[i]   <= 1'b0;
      end else begin
        press_q[i] <= flip & sync_b[i];
        rel_q[i]   <= flip & ~sync_b[i];
        if ((sync_b[i] == level_q[i]) || flip) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (flip) begin
          level_q[i] <= sync_b[i];
        end
      end
    end

    if (REPEAT_EN != 0) begin : g_rpt
      rpt_state_t       state;
      logic [RPT_W-1:0] rc;

      // The FSM keys off the same-edge flip so the first rpt lands exactly REPEAT_DELAY edges after press.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state    <= IDLE;
          rc       <= '0;
          rpt_q[i] <= 1'b0;
        end else begin
          rpt_q[i] <= 1'b0;
          case (state)
            IDLE: begin
              if (flip && sync_b[i]) begin
                state <= HOLD;
                rc    <= '0;
              end
            end
            HOLD: begin
              if (flip) begin
                state <= IDLE;
                rc    <= '0;
              end else if (rc == DELAY_LAST) begin
                state    <= REPEAT;
                rc       <= '0;
                rpt_q[i] <= 1'b1;
              end else begin
                rc <= rc + 1'b1;
              end
            end
            REPEAT: begin
              if (flip) begin
                state <= IDLE;
                rc    <= '0;
              end else if (rc == RATE_LAST) begin
                rc       <= '0;
                rpt_q[i] <= 1'b1;
              end else begin
                rc <= rc + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              rc    <= '0;
            end
          endcase
        end
      end
    end else begin : g_no_rpt
      assign rpt_q[i] = 1'b0;
    end
  end

  assign bus.level = level_q;
  assign bus.press = press_q;
  assign bus.rel   = rel_q;
  assign bus.rpt   = rpt_q;

endmodule
